// File: rtl/score_credit_keeper.sv
// Score/credit bookkeeping: queues award pulses, converts them to BCD by double dabble,
// adds them into a saturating 4-digit BCD score, and keeps the high score and credit count.
module score_credit_keeper #(
   parameter int MAX_CREDITS = 9,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  scoreUpdate,
   input  logic        startGame,
   input  logic        gameEnded,
   input  logic        coinN,
   output logic [3:0]  credits,
   output logic [15:0] score,
   output logic [15:0] hiScore,
   output logic        busy,
   output logic        dropped
);
   typedef enum logic [1:0] {IDLE, CONV, ADD} stateT;

   localparam logic [3:0] MAX_C = 4'(MAX_CREDITS);
   localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

   logic startQ, startQQ, endQ, endQQ, coinQ, coinQQ;
   logic startRise, endRise, coinFall;

   always_ff @(posedge clk) begin
      if (reset) begin
         startQ  <= 1'b0;
         startQQ <= 1'b0;
         endQ    <= 1'b0;
         endQQ   <= 1'b0;
         coinQ   <= 1'b1;
         coinQQ  <= 1'b1;
      end else begin
         startQ  <= startGame;
         startQQ <= startQ;
         endQ    <= gameEnded;
         endQQ   <= endQ;
         coinQ   <= coinN;
         coinQQ  <= coinQ;
      end
   end

   assign startRise = startQ & ~startQQ;
   assign endRise   = endQ & ~endQQ;
   assign coinFall  = ~coinQ & coinQQ;

   // A coin and a start together cancel, except at saturation where the coin is lost.
   always_ff @(posedge clk) begin
      if (reset)
         credits <= 4'd0;
      else if (coinFall && startRise) begin
         if (credits == MAX_C) credits <= MAX_C - 4'd1;
      end else if (coinFall) begin
         if (credits != MAX_C) credits <= credits + 4'd1;
      end else if (startRise && credits != 4'd0)
         credits <= credits - 4'd1;
   end

   stateT       state;
   logic [7:0]  fifoMem [0:3];
   logic [2:0]  fifoCnt;
   logic [7:0]  shiftReg;
   logic [11:0] bcdAcc;
   logic [11:0] accAdj;
   logic [2:0]  bitCnt;
   logic [1:0]  digitIdx;
   logic        carry;
   logic [11:0] work;
   logic        clearPend, hiPend;
   logic        push, pop, full, pushOk, clearSvc;
   logic [1:0]  wIdx;
   logic [3:0]  scoreDig, digRes;
   logic [4:0]  digSum;
   logic        digCarry;

   function automatic logic [11:0] dabble(input logic [11:0] a);
      logic [11:0] r;
      r = a;
      for (int d = 0; d < 3; d++)
         if (a[4*d +: 4] >= 4'd5) r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      return r;
   endfunction

   assign full     = (fifoCnt == DEPTH);
   assign push     = |scoreUpdate;
   assign clearSvc = (state == IDLE) && clearPend;
   assign pop      = (state == IDLE) && !clearPend && !hiPend && (fifoCnt != 3'd0);
   assign pushOk   = push && (!full || pop);
   assign wIdx     = 2'(pop ? fifoCnt - 3'd1 : fifoCnt);

   assign accAdj   = dabble(bcdAcc);
   // The award is shifted right one digit per ADD cycle, so its low nibble is the current digit.
   assign scoreDig = score[{digitIdx, 2'b00} +: 4];
   assign digSum   = {1'b0, scoreDig} + {1'b0, bcdAcc[3:0]} + {4'd0, carry};
   assign digCarry = digSum > 5'd9;
   assign digRes   = digCarry ? 4'(digSum - 5'd10) : digSum[3:0];

   always_ff @(posedge clk) begin
      if (pop)
         for (int i = 0; i < FIFO_DEPTH - 1; i++) fifoMem[i] <= fifoMem[i+1];
      if (pushOk) fifoMem[wIdx] <= scoreUpdate;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         dropped   <= 1'b0;
         score     <= 16'd0;
         hiScore   <= 16'd0;
         clearPend <= 1'b0;
         hiPend    <= 1'b0;
         fifoCnt   <= 3'd0;
         shiftReg  <= 8'd0;
         bcdAcc    <= 12'd0;
         bitCnt    <= 3'd0;
         digitIdx  <= 2'd0;
         carry     <= 1'b0;
         work      <= 12'd0;
      end else begin
         if (clearSvc) fifoCnt <= 3'd0;
         else          fifoCnt <= fifoCnt + 3'(pushOk) - 3'(pop);

         if (clearSvc)                  dropped <= 1'b0;
         else if (push && full && !pop) dropped <= 1'b1;

         unique case (state)
            IDLE: begin
               if (clearPend) begin
                  score     <= 16'd0;
                  clearPend <= 1'b0;
               end else if (hiPend) begin
                  // Valid BCD orders the same as plain binary, MSD first.
                  if (score > hiScore) hiScore <= score;
                  hiPend <= 1'b0;
               end else if (pop) begin
                  shiftReg <= fifoMem[0];
                  bcdAcc   <= 12'd0;
                  bitCnt   <= 3'd0;
                  state    <= CONV;
                  busy     <= 1'b1;
               end
            end
            CONV: begin
               {bcdAcc, shiftReg} <= {accAdj, shiftReg} << 1;
               bitCnt <= bitCnt + 3'd1;
               if (bitCnt == 3'd7) begin
                  state    <= ADD;
                  digitIdx <= 2'd0;
                  carry    <= 1'b0;
               end
            end
            ADD: begin
               carry    <= digCarry;
               work     <= {digRes, work[11:4]};
               bcdAcc   <= {4'd0, bcdAcc[11:4]};
               digitIdx <= digitIdx + 2'd1;
               if (digitIdx == 2'd3) begin
                  score <= digCarry ? 16'h9999 : {digRes, work};
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (startRise) clearPend <= 1'b1;
         if (endRise)   hiPend    <= 1'b1;
      end
   end
endmodule

// File: tb/tb_score_credit_keeper.sv
// Bench for score_credit_keeper: directed scenarios plus a randomized award/coin run
// compared cycle by cycle against a queue-based reference model.
module tb_score_credit_keeper;
   localparam int MAXC  = 9;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  scoreUpdate = 8'd0;
   logic        startGame = 1'b0;
   logic        gameEnded = 1'b0;
   logic        coinN = 1'b1;
   logic [3:0]  credits;
   logic [15:0] score, hiScore;
   logic        busy, dropped;

   int tests = 0;
   int fails = 0;

   score_credit_keeper #(.MAX_CREDITS(MAXC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .scoreUpdate(scoreUpdate), .startGame(startGame),
      .gameEnded(gameEnded), .coinN(coinN), .credits(credits), .score(score),
      .hiScore(hiScore), .busy(busy), .dropped(dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] toBcd(input int v);
      return 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
                 (((v / 10) % 10) << 4) | (v % 10));
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b1; scoreUpdate = 8'd0; startGame = 1'b0; gameEnded = 1'b0; coinN = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic award(input logic [7:0] v);
      scoreUpdate = v; cyc(1);
      scoreUpdate = 8'd0; cyc(16);
   endtask

   task automatic coin();
      coinN = 1'b0; cyc(1);
      coinN = 1'b1; cyc(1);
   endtask

   task automatic startPulse();
      startGame = 1'b1; cyc(1);
      startGame = 1'b0; cyc(1);
   endtask

   task automatic endPulse();
      gameEnded = 1'b1; cyc(1);
      gameEnded = 1'b0; cyc(1);
   endtask

   // reference model state for the randomized run
   int q[$];
   int mScore, mCred, busyLeft, cur;
   bit mDrop, c1, c2, fall;

   initial begin
      int busyCnt;
      doReset();
      chk("rst_credits", 32'(credits), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_hi", 32'(hiScore), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dropped", 32'(dropped), 0);

      // single award latency
      scoreUpdate = 8'd30; cyc(1);
      scoreUpdate = 8'd0;
      chk("e0_busy", 32'(busy), 0);
      busyCnt = 0;
      for (int k = 1; k <= 13; k++) begin
         cyc(1);
         if (busy) busyCnt++;
         if (k == 12) chk("e12_score", 32'(score), 0);
         if (k == 13) begin
            chk("e13_score", 32'(score), 32'h0030);
            chk("e13_busy", 32'(busy), 0);
         end
      end
      chk("busy_len", busyCnt, 12);

      // BCD carry
      award(8'd65);
      chk("score_95", 32'(score), 32'h0095);
      award(8'd10);
      chk("score_105", 32'(score), 32'h0105);

      // saturation
      doReset();
      for (int i = 0; i < 39; i++) award(8'd255);
      award(8'd45);
      chk("score_9990", 32'(score), 32'h9990);
      award(8'd100);
      chk("sat_9999", 32'(score), 32'h9999);
      award(8'd10);
      chk("sat_hold", 32'(score), 32'h9999);

      // burst overflow
      doReset();
      scoreUpdate = 8'd10; cyc(1);
      scoreUpdate = 8'd20; cyc(1);
      scoreUpdate = 8'd30; cyc(1);
      scoreUpdate = 8'd40; cyc(1);
      scoreUpdate = 8'd0;  cyc(50);
      chk("burst_score", 32'(score), 32'h0060);
      chk("burst_drop", 32'(dropped), 1);

      // credits
      doReset();
      for (int i = 0; i < 11; i++) coin();
      cyc(3);
      chk("cred_sat", 32'(credits), 9);
      startPulse(); cyc(3);
      chk("cred_dec", 32'(credits), 8);
      coinN = 1'b0; startGame = 1'b1; cyc(1);
      coinN = 1'b1; startGame = 1'b0; cyc(4);
      chk("cred_both8", 32'(credits), 8);
      for (int i = 0; i < 9; i++) startPulse();
      cyc(3);
      chk("cred_floor", 32'(credits), 0);
      for (int i = 0; i < 9; i++) coin();
      coinN = 1'b0; startGame = 1'b1; cyc(1);
      coinN = 1'b1; startGame = 1'b0; cyc(4);
      chk("cred_both9", 32'(credits), 8);

      // high score and new game
      doReset();
      award(8'd100);
      endPulse(); cyc(3);
      chk("hi_100", 32'(hiScore), 32'h0100);
      award(8'd20);
      endPulse(); cyc(3);
      chk("hi_120", 32'(hiScore), 32'h0120);
      startPulse(); cyc(3);
      chk("new_score", 32'(score), 0);
      chk("new_hi", 32'(hiScore), 32'h0120);
      award(8'd50);
      endPulse(); cyc(3);
      chk("hi_keep", 32'(hiScore), 32'h0120);
      chk("low_score", 32'(score), 32'h0050);

      // reset during ADD
      doReset();
      coin(); coin();
      award(8'd30);
      endPulse(); cyc(3);
      chk("pre_hi", 32'(hiScore), 32'h0030);
      chk("pre_cred", 32'(credits), 2);
      scoreUpdate = 8'd40; cyc(1);
      scoreUpdate = 8'd0;  cyc(10);
      chk("mid_busy", 32'(busy), 1);
      reset = 1'b1; cyc(1);
      chk("abort_score", 32'(score), 0);
      chk("abort_hi", 32'(hiScore), 0);
      chk("abort_cred", 32'(credits), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_drop", 32'(dropped), 0);
      reset = 1'b0; cyc(20);
      chk("abort_final", 32'(score), 0);

      // randomized awards and coins against the reference model
      doReset();
      q.delete();
      mScore = 0; mCred = 0; busyLeft = 0; cur = 0; mDrop = 1'b0; c1 = 1'b1; c2 = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         scoreUpdate = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         if ($urandom_range(0, 5) == 0) coinN = ~coinN;
         @(posedge clk);
         fall = !c1 && c2;
         c2 = c1; c1 = coinN;
         mCred = mCred + int'(fall);
         if (mCred > MAXC) mCred = MAXC;
         if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) begin
               mScore = mScore + cur;
               if (mScore > 9999) mScore = 9999;
            end
         end else if (q.size() > 0) begin
            cur = q.pop_front();
            busyLeft = 12;
         end
         if (scoreUpdate != 8'd0) begin
            if (q.size() < DEPTH) q.push_back(int'(scoreUpdate));
            else mDrop = 1'b1;
         end
         @(negedge clk);
         chk("rnd_score", 32'(score), 32'(toBcd(mScore)));
         chk("rnd_busy", 32'(busy), 32'(busyLeft > 0));
         chk("rnd_drop", 32'(dropped), 32'(mDrop));
         chk("rnd_cred", 32'(credits), mCred);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
